// File: rtl/fetch_decode_if.sv
// Shared stage/opcode encodings and the program-ROM fetch handshake
// between the sequencer (master) and the instruction ROM (slave).
package fetch_decode_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4
  } stage_t;

  // Encodings follow the raw opcode so the ALU sees familiar values; 4'h8 is a spare slot reused as NOP.
  typedef enum logic [3:0] {
    ADD_A_IMM = 4'h0,
    MOV_A_B   = 4'h1,
    IN_A      = 4'h2,
    MOV_A_IMM = 4'h3,
    MOV_B_A   = 4'h4,
    ADD_B_IMM = 4'h5,
    IN_B      = 4'h6,
    MOV_B_IMM = 4'h7,
    NOP       = 4'h8,
    OUT_B     = 4'h9,
    OUT_IMM   = 4'hB,
    JNC_IMM   = 4'hE,
    JMP_IMM   = 4'hF
  } opecode_t;

endpackage

interface fetch_decode_if;
  logic       rom_req;
  logic [3:0] rom_addr;
  logic       rom_valid;
  logic [7:0] rom_data;

  modport master (output rom_req, rom_addr, input rom_valid, rom_data);
  modport slave  (input rom_req, rom_addr, output rom_valid, rom_data);
endinterface

// File: rtl/fetch_decode.sv
// Front-end sequencer for the 4-bit CPU: fetches an instruction from ROM,
// decodes it and steps the ALU/register file through EXECUTE and WRITEBACK.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step,
  input  logic [3:0]         pc,
  fetch_decode_if.master     rom,
  output stage_t             stage,
  output opecode_t           opecode,
  output logic [3:0]         imm,
  output logic               reg_we,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_FAULT
  } state_t;

  state_t             state;
  logic [7:0]         ir;
  logic               dvalid;
  logic [3:0]         addr_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               single;
  logic [COUNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ir       <= 8'h00;
      dvalid   <= 1'b0;
      addr_q   <= 4'h0;
      wait_cnt <= '0;
      single   <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            addr_q   <= pc;
            wait_cnt <= '0;
          end else if (step) begin
            state    <= S_FETCH;
            addr_q   <= pc;
            wait_cnt <= '0;
            single   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (rom.rom_valid) begin
            ir     <= rom.rom_data;
            dvalid <= 1'b1;
            state  <= S_DECODE;
          end else if (wait_cnt == WAIT_W'(FETCH_TIMEOUT - 1)) begin
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE:  state <= S_EXECUTE;
        S_EXECUTE: state <= S_WRITEBACK;
        S_WRITEBACK: begin
          count <= count + 1'b1;
          // A single-step request retires exactly one instruction even if run rose meanwhile.
          if (run && !single) begin
            state    <= S_FETCH;
            addr_q   <= pc;
            wait_cnt <= '0;
          end else begin
            state  <= S_IDLE;
            single <= 1'b0;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rom.rom_req  = (state == S_FETCH);
  assign rom.rom_addr = addr_q;
  assign reg_we       = (state == S_WRITEBACK);
  assign fault        = (state == S_FAULT);
  assign instr_count  = count;
  assign imm          = ir[3:0];

  always_comb begin
    stage = IDLE;
    case (state)
      S_FETCH:     stage = FETCH;
      S_DECODE:    stage = DECODE;
      S_EXECUTE:   stage = EXECUTE;
      S_WRITEBACK: stage = WRITEBACK;
      default:     stage = IDLE;
    endcase
  end

  // Decode-valid keeps the reset-time IR (8'h00) from reading as ADD_A_IMM.
  always_comb begin
    opecode = NOP;
    if (dvalid) begin
      case (ir[7:4])
        4'b0000: opecode = ADD_A_IMM;
        4'b0001: opecode = MOV_A_B;
        4'b0010: opecode = IN_A;
        4'b0011: opecode = MOV_A_IMM;
        4'b0100: opecode = MOV_B_A;
        4'b0101: opecode = ADD_B_IMM;
        4'b0110: opecode = IN_B;
        4'b0111: opecode = MOV_B_IMM;
        4'b1001: opecode = OUT_B;
        4'b1011: opecode = OUT_IMM;
        4'b1110: opecode = JNC_IMM;
        4'b1111: opecode = JMP_IMM;
        default: opecode = NOP;
      endcase
    end
  end

endmodule
